// File: rtl/axis_capture_ptr_if.sv
// AXIS sink stream plus capture-memory write port for axis_capture_ptr.
// slave = capture block view, master = stream source / memory view.
interface axis_capture_ptr_if #(
   parameter int DATA_W = 512,
   parameter int ADDR_W = 11
);
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid,
      output s_axis_tready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid,
      input  s_axis_tready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/axis_capture_ptr.sv
// AXIS capture sink: writes stream beats into a word-addressed memory between
// GPIO start/stop byte pointers, one-shot or looping, with 1-cycle write latency.
module axis_capture_ptr #(
   parameter int DATA_W         = 512,
   parameter int BYTES_PER_WORD = 64,
   parameter int ADDR_W         = 11,
   parameter int PTR_W          = 32
) (
   input  logic                axis_clk,
   input  logic                axis_rst,
   axis_capture_ptr_if.slave   bus,
   input  logic                cap_en_i,
   input  logic                loop_mode_i,
   input  logic [PTR_W-1:0]    start_ptr_i,
   input  logic [PTR_W-1:0]    stop_ptr_i,
   output logic                cap_busy_o,
   output logic                cap_done_o,
   output logic                cap_err_o,
   output logic [31:0]         beat_count_o,
   output logic [15:0]         wrap_count_o
);
   localparam int SHIFT = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_e;

   state_e            state_q, state_d;
   logic              cap_en_q, arm_ok_q;
   logic              tready_q, tready_d;
   logic              loop_q, loop_d;
   logic [ADDR_W-1:0] start_w_q, start_w_d;
   logic [ADDR_W-1:0] stop_w_q, stop_w_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]       beat_q, beat_d;
   logic [15:0]       wrap_q, wrap_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [ADDR_W-1:0] start_word, stop_word;
   logic              hs, rise;
   logic              unused_ptr_bits;

   assign start_word = start_ptr_i[ADDR_W+SHIFT-1:SHIFT];
   assign stop_word  = stop_ptr_i[ADDR_W+SHIFT-1:SHIFT];
   assign unused_ptr_bits = ^{start_ptr_i[SHIFT-1:0], stop_ptr_i[SHIFT-1:0],
                              start_ptr_i[PTR_W-1:ADDR_W+SHIFT], stop_ptr_i[PTR_W-1:ADDR_W+SHIFT]};

   assign hs   = bus.s_axis_tvalid & tready_q;
   // arm_ok_q forces cap_en to be seen low after reset, so a level held
   // high across reset never counts as a fresh rising edge.
   assign rise = cap_en_i & ~cap_en_q & arm_ok_q;

   always_comb begin
      state_d   = state_q;
      tready_d  = tready_q;
      loop_d    = loop_q;
      start_w_d = start_w_q;
      stop_w_d  = stop_w_q;
      wr_ptr_d  = wr_ptr_q;
      beat_d    = beat_q;
      wrap_d    = wrap_q;
      done_d    = done_q;
      err_d     = err_q;
      we_d      = hs;
      addr_d    = hs ? wr_ptr_q : addr_q;
      wdata_d   = hs ? bus.s_axis_tdata : wdata_q;

      case (state_q)
         S_IDLE: begin
            tready_d = 1'b0;
            if (rise) begin
               start_w_d = start_word;
               stop_w_d  = stop_word;
               loop_d    = loop_mode_i;
               beat_d    = '0;
               wrap_d    = '0;
               done_d    = 1'b0;
               err_d     = 1'b0;
               if (stop_word < start_word) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  wr_ptr_d = start_word;
                  tready_d = 1'b1;
                  state_d  = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (hs) begin
               beat_d = (beat_q == '1) ? beat_q : beat_q + 32'd1;
               if (wr_ptr_q == stop_w_q) begin
                  if (loop_q) begin
                     wr_ptr_d = start_w_q;
                     wrap_d   = (wrap_q == '1) ? wrap_q : wrap_q + 16'd1;
                  end else begin
                     state_d  = S_DONE;
                     tready_d = 1'b0;
                     done_d   = 1'b1;
                  end
               end else begin
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               end
            end
            // Abort wins over a simultaneous final beat: the beat is still
            // written, but the capture is not reported as done.
            if (!cap_en_i) begin
               state_d  = S_IDLE;
               tready_d = 1'b0;
               done_d   = 1'b0;
            end
         end
         S_DONE: begin
            tready_d = 1'b0;
            if (!cap_en_i) state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            tready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state_q   <= S_IDLE;
         cap_en_q  <= 1'b0;
         arm_ok_q  <= 1'b0;
         tready_q  <= 1'b0;
         loop_q    <= 1'b0;
         start_w_q <= '0;
         stop_w_q  <= '0;
         wr_ptr_q  <= '0;
         beat_q    <= '0;
         wrap_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cap_en_q  <= cap_en_i;
         arm_ok_q  <= arm_ok_q | ~cap_en_i;
         tready_q  <= tready_d;
         loop_q    <= loop_d;
         start_w_q <= start_w_d;
         stop_w_q  <= stop_w_d;
         wr_ptr_q  <= wr_ptr_d;
         beat_q    <= beat_d;
         wrap_q    <= wrap_d;
         done_q    <= done_d;
         err_q     <= err_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus.s_axis_tready = tready_q;
   assign bus.mem_we        = we_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;
   assign cap_busy_o        = (state_q == S_CAPTURE);
   assign cap_done_o        = done_q;
   assign cap_err_o         = err_q;
   assign beat_count_o      = beat_q;
   assign wrap_count_o      = wrap_q;
endmodule

// File: tb/tb_axis_capture_ptr.sv
// Directed vector table plus hand sequences for abort and reset on axis_capture_ptr.
module tb_axis_capture_ptr;
   localparam int DATA_W = 512;
   localparam int ADDR_W = 11;

   logic        clk = 1'b0;
   logic        rst;
   logic        cap_en, loop_mode;
   logic [31:0] start_ptr, stop_ptr;
   logic        busy, done, err;
   logic [31:0] beats;
   logic [15:0] wraps;

   always #5 clk = ~clk;

   axis_capture_ptr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   axis_capture_ptr #(.DATA_W(DATA_W), .BYTES_PER_WORD(64), .ADDR_W(ADDR_W), .PTR_W(32)) dut (
      .axis_clk     (clk),
      .axis_rst     (rst),
      .bus          (bus),
      .cap_en_i     (cap_en),
      .loop_mode_i  (loop_mode),
      .start_ptr_i  (start_ptr),
      .stop_ptr_i   (stop_ptr),
      .cap_busy_o   (busy),
      .cap_done_o   (done),
      .cap_err_o    (err),
      .beat_count_o (beats),
      .wrap_count_o (wraps)
   );

   typedef struct {
      string       name;
      logic [31:0] start, stop;
      logic        loop;
      int          cycles;
      logic        toggle;
      int          exp_writes, exp_base, exp_period, exp_beats, exp_wraps;
      logic        exp_done, exp_err, exp_busy, exp_rdy_end, exp_rdy_seen;
   } vec_t;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int dctr = 1;
   logic rdy_seen;

   logic [ADDR_W-1:0] wa_q[$];
   logic [DATA_W-1:0] wd_q[$];
   int                wc_q[$];
   logic [DATA_W-1:0] hs_d[$];
   int                hs_c[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Record each write with the edge at which a memory would sample it.
   always @(negedge clk) begin
      if (bus.mem_we) begin
         wa_q.push_back(bus.mem_addr);
         wd_q.push_back(bus.mem_wdata);
         wc_q.push_back(cyc + 1);
      end
   end

   task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_beat(input logic v);
      bus.s_axis_tvalid = v;
      bus.s_axis_tdata  = {16{dctr}};
      if (bus.s_axis_tready) rdy_seen = 1'b1;
      if (v && bus.s_axis_tready) begin
         hs_d.push_back(bus.s_axis_tdata);
         hs_c.push_back(cyc + 1);
         dctr++;
      end
      tick();
   endtask

   task automatic clear_logs();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
      hs_d.delete(); hs_c.delete();
      rdy_seen = 1'b0;
   endtask

   task automatic check_writes(input string nm, input int n, input int base, input int period);
      int m;
      chk({nm, " nwrites"}, DATA_W'(wa_q.size()), DATA_W'(n));
      m = (wa_q.size() < n) ? wa_q.size() : n;
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s addr[%0d]", nm, i), DATA_W'(wa_q[i]), DATA_W'(base + (i % period)));
         if (i < hs_d.size()) begin
            chk($sformatf("%s data[%0d]", nm, i), wd_q[i], hs_d[i]);
            chk($sformatf("%s lat[%0d]", nm, i), DATA_W'(wc_q[i]), DATA_W'(hs_c[i] + 1));
         end
      end
   endtask

   function automatic vec_t mk(string nm, logic [31:0] s, logic [31:0] e, logic l, int cy, logic tg,
                               int w, int b, int p, int bt, int wr,
                               logic d, logic er, logic bz, logic re, logic rs);
      vec_t v;
      v.name = nm; v.start = s; v.stop = e; v.loop = l; v.cycles = cy; v.toggle = tg;
      v.exp_writes = w; v.exp_base = b; v.exp_period = p; v.exp_beats = bt; v.exp_wraps = wr;
      v.exp_done = d; v.exp_err = er; v.exp_busy = bz; v.exp_rdy_end = re; v.exp_rdy_seen = rs;
      return v;
   endfunction

   vec_t vt[8];

   initial begin
      //             name         start         stop          lp cyc tg  wr  base per bts wrp dn er bz re rs
      vt[0] = mk("oneshot",     32'h0,        32'hC00,      0, 60, 0, 49,    0, 49, 49, 0, 1, 0, 0, 0, 1);
      vt[1] = mk("loop",        32'h1000,     32'h10FF,     1, 10, 0, 10,   64,  4, 10, 2, 0, 0, 1, 1, 1);
      vt[2] = mk("ptr_err",     32'h800,      32'h400,      0, 10, 0,  0,    0,  1,  0, 0, 0, 1, 0, 0, 0);
      vt[3] = mk("toggle",      32'h0,        32'h3C0,      0, 40, 1, 16,    0, 16, 16, 0, 1, 0, 0, 0, 1);
      vt[4] = mk("unaligned",   32'hFFFF0041, 32'hFFFF00FF, 0, 10, 0,  3, 1025,  3,  3, 0, 1, 0, 0, 0, 1);
      vt[5] = mk("single",      32'h40,       32'h7F,       0, 10, 0,  1,    1,  1,  1, 0, 1, 0, 0, 0, 1);
      vt[6] = mk("single_loop", 32'h40,       32'h7F,       1,  5, 0,  5,    1,  1,  5, 5, 0, 0, 1, 1, 1);
      vt[7] = mk("top_word",    32'h1FF80,    32'h1FFFF,    0, 10, 0,  2, 2046,  2,  2, 0, 1, 0, 0, 0, 1);

      rst = 1'b1; cap_en = 1'b0; loop_mode = 1'b0; start_ptr = '0; stop_ptr = '0;
      bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0;
      @(negedge clk);
      tick(); tick();
      chk("rst tready", DATA_W'(bus.s_axis_tready), '0);
      chk("rst mem_we", DATA_W'(bus.mem_we), '0);
      chk("rst mem_addr", DATA_W'(bus.mem_addr), '0);
      chk("rst mem_wdata", bus.mem_wdata, '0);
      chk("rst busy", DATA_W'(busy), '0);
      chk("rst done", DATA_W'(done), '0);
      chk("rst err", DATA_W'(err), '0);
      chk("rst beats", DATA_W'(beats), '0);
      chk("rst wraps", DATA_W'(wraps), '0);
      rst = 1'b0;

      foreach (vt[k]) begin
         cap_en = 1'b0; bus.s_axis_tvalid = 1'b0;
         tick(); tick(); tick();
         clear_logs();
         start_ptr = vt[k].start; stop_ptr = vt[k].stop; loop_mode = vt[k].loop;
         cap_en = 1'b1;
         tick();
         // Scramble the pointer inputs after arming; they must be ignored.
         start_ptr = 32'h0; stop_ptr = 32'hFFFF_FFFF; loop_mode = ~vt[k].loop;
         for (int c = 0; c < vt[k].cycles; c++)
            drive_beat(vt[k].toggle ? logic'(c % 2 == 0) : 1'b1);
         chk({vt[k].name, " busy"}, DATA_W'(busy), DATA_W'(vt[k].exp_busy));
         chk({vt[k].name, " tready_end"}, DATA_W'(bus.s_axis_tready), DATA_W'(vt[k].exp_rdy_end));
         chk({vt[k].name, " done"}, DATA_W'(done), DATA_W'(vt[k].exp_done));
         chk({vt[k].name, " err"}, DATA_W'(err), DATA_W'(vt[k].exp_err));
         chk({vt[k].name, " beats"}, DATA_W'(beats), DATA_W'(vt[k].exp_beats));
         chk({vt[k].name, " wraps"}, DATA_W'(wraps), DATA_W'(vt[k].exp_wraps));
         chk({vt[k].name, " tready_seen"}, DATA_W'(rdy_seen), DATA_W'(vt[k].exp_rdy_seen));
         bus.s_axis_tvalid = 1'b0;
         tick(); tick();
         check_writes(vt[k].name, vt[k].exp_writes, vt[k].exp_base, vt[k].exp_period);
      end

      // Abort after 5 beats; the beat coinciding with cap_en falling is kept.
      cap_en = 1'b0; bus.s_axis_tvalid = 1'b0;
      tick(); tick(); tick();
      clear_logs();
      start_ptr = 32'h0; stop_ptr = 32'hC00; loop_mode = 1'b0;
      cap_en = 1'b1;
      tick();
      for (int c = 0; c < 4; c++) drive_beat(1'b1);
      cap_en = 1'b0;
      drive_beat(1'b1);
      chk("abort tready", DATA_W'(bus.s_axis_tready), '0);
      chk("abort busy", DATA_W'(busy), '0);
      chk("abort done", DATA_W'(done), '0);
      for (int c = 0; c < 3; c++) drive_beat(1'b1);
      bus.s_axis_tvalid = 1'b0;
      tick();
      chk("abort beats", DATA_W'(beats), DATA_W'(5));
      check_writes("abort", 5, 0, 5);
      clear_logs();
      cap_en = 1'b1;
      tick();
      chk("rearm beats", DATA_W'(beats), '0);
      chk("rearm busy", DATA_W'(busy), DATA_W'(1));
      drive_beat(1'b1);
      drive_beat(1'b1);
      bus.s_axis_tvalid = 1'b0;
      tick();
      check_writes("rearm", 2, 0, 2);

      // Reset in the middle of a capture, with cap_en held high throughout.
      drive_beat(1'b1);
      drive_beat(1'b1);
      rst = 1'b1;
      drive_beat(1'b1);
      chk("midrst tready", DATA_W'(bus.s_axis_tready), '0);
      chk("midrst mem_we", DATA_W'(bus.mem_we), '0);
      chk("midrst mem_addr", DATA_W'(bus.mem_addr), '0);
      chk("midrst mem_wdata", bus.mem_wdata, '0);
      chk("midrst busy", DATA_W'(busy), '0);
      chk("midrst beats", DATA_W'(beats), '0);
      rst = 1'b0;
      clear_logs();
      for (int c = 0; c < 5; c++) drive_beat(1'b1);
      chk("held_en busy", DATA_W'(busy), '0);
      chk("held_en tready_seen", DATA_W'(rdy_seen), '0);
      chk("held_en nwrites", DATA_W'(wa_q.size()), '0);
      bus.s_axis_tvalid = 1'b0;
      cap_en = 1'b0;
      tick();
      cap_en = 1'b1;
      tick();
      chk("rearm2 busy", DATA_W'(busy), DATA_W'(1));
      chk("rearm2 tready", DATA_W'(bus.s_axis_tready), DATA_W'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/axis_capture_ptr.md
Name: axis_capture_ptr

Overview:
- AXIS sink: the receive-side counterpart of the URAM pointer playback block.
- Accepts a 512-bit AXIS stream on axis_clk and writes each beat into a word-addressed capture memory (BRAM/URAM write port).
- Writes run from a start byte pointer to a stop byte pointer. Pointers and enable come from AXI GPIOs.
- Supports one-shot capture or looped capture (wrap back to start) for on-board bring-up and for loopback checking of the DAC playback path.

Parameters:
- DATA_W, 512, AXIS tdata / memory word width in bits.
- BYTES_PER_WORD, 64, bytes per memory word; pointer to word-address shift is log2 of this value (6).
- ADDR_W, 11, memory word address width (2048 words = 128 KiB).
- PTR_W, 32, width of the GPIO byte pointers.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_W  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- cap_en  in  1  capture enable (GPIO bit 0). Level-sensitive; a rising edge arms a capture.
- loop_mode  in  1  0 = one-shot, 1 = wrap to start at stop.
- start_ptr  in  PTR_W  start byte address (GPIO).
- stop_ptr  in  PTR_W  stop byte address, inclusive (GPIO).
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- cap_busy  out  1  high in CAPTURE state.
- cap_done  out  1  one-shot capture finished.
- cap_err  out  1  pointer error on arm.
- beat_count  out  32  beats written since arm; saturates at 2^32-1.
- wrap_count  out  16  loop wraps since arm; saturates.

Behaviour:
- Reset (axis_rst=1 at posedge): state=IDLE; s_axis_tready, mem_we, cap_busy, cap_done, cap_err = 0; mem_addr, mem_wdata, beat_count, wrap_count = 0; cap_en edge register = 0.
- Pointer conversion: word = ptr[ADDR_W+5:6]. Low 6 bits are ignored (unaligned pointers truncate down). Bits above ADDR_W+5 are ignored.
- IDLE:
  - tready=0.
  - On a cap_en rising edge (cap_en=1 and previous cap_en=0): latch start_word, stop_word and loop_mode; clear beat_count, wrap_count, cap_done and cap_err.
  - If stop_word < start_word: set cap_err=1 and go to DONE.
  - Otherwise set wr_ptr=start_word and go to CAPTURE.
  - Pointer or loop_mode changes while not in IDLE have no effect until the next arm.
- CAPTURE:
  - tready=1 (registered; high from the first cycle in CAPTURE).
  - On each beat (tvalid & tready): the next cycle asserts mem_we=1 with mem_addr=wr_ptr and mem_wdata=tdata, i.e. 1-cycle write latency. beat_count increments.
  - At wr_ptr==stop_word with loop_mode=1: wr_ptr=start_word and wrap_count increments.
  - At wr_ptr==stop_word with loop_mode=0: tready drops in the same cycle as state moves to DONE. No further beats are accepted.
  - Otherwise wr_ptr increments.
  - Back-to-back beats are accepted every cycle. tvalid low stalls with no write.
  - start_word==stop_word: one-shot captures exactly 1 beat; loop mode rewrites the same word every beat.
- Abort: cap_en=0 while in CAPTURE:
  - tready drops the next cycle and state goes to IDLE.
  - A beat handshaked in the same cycle that cap_en falls is still written.
  - cap_done stays 0 on abort.
- DONE:
  - tready=0; cap_done=1, unless entered via error (cap_err=1, cap_done=0).
  - Holds until cap_en=0, then goes to IDLE. cap_done and cap_err stay asserted in IDLE until the next arm.
- mem_we is a single-cycle pulse per beat. mem_addr and mem_wdata hold their last value when mem_we=0.
- cap_busy = (state==CAPTURE).
- Reset mid-capture: everything returns to reset values on the next edge; an in-flight write is dropped.

Test Plan:
- Reset, start_ptr=0, stop_ptr=0xC00, loop_mode=0, cap_en 0->1, continuous tvalid with incrementing data -> 49 writes to addresses 0..48 (0xC00 is word 48), data matches, cap_done=1, beat_count=49, tready=0 after beat 49.
- start_ptr=0x1000, stop_ptr=0x10FF, loop_mode=1, 10 beats -> addresses 64,65,66,67,64,65,66,67,64,65; wrap_count=2; cap_busy stays 1.
- start_ptr=0x800, stop_ptr=0x400 -> cap_err=1, cap_done=0, no mem_we, tready never asserts.
- tvalid toggling 1/0 every cycle, stop=0x3C0 -> 16 writes on consecutive addresses, each mem_we exactly one cycle after its handshake.
- Abort after 5 beats of a 0..0xC00 capture by dropping cap_en -> 5 writes (addresses 0..4), IDLE, cap_done=0; re-arming restarts at address 0 with beat_count=0.
- Assert axis_rst during CAPTURE -> all outputs 0 next cycle; holding cap_en high after reset does not re-arm until it falls and rises again.
